// File: rtl/rv32i_enc_pkg.sv
// Shared constants for the RV32I encoder: instruction IDs, opcodes, formats and ID decode.
// funct3/funct7 tables are held in decodeId().
package rv32i_enc_pkg;

    localparam logic [5:0]
        ID_LUI = 6'd0, ID_AUIPC = 6'd1, ID_JAL = 6'd2, ID_JALR = 6'd3,
        ID_BEQ = 6'd4, ID_BNE = 6'd5, ID_BLT = 6'd6, ID_BGE = 6'd7, ID_BLTU = 6'd8, ID_BGEU = 6'd9,
        ID_LB = 6'd10, ID_LH = 6'd11, ID_LW = 6'd12, ID_LBU = 6'd13, ID_LHU = 6'd14,
        ID_SB = 6'd15, ID_SH = 6'd16, ID_SW = 6'd17,
        ID_ADDI = 6'd18, ID_SLTI = 6'd19, ID_SLTIU = 6'd20, ID_XORI = 6'd21, ID_ORI = 6'd22,
        ID_ANDI = 6'd23, ID_SLLI = 6'd24, ID_SRLI = 6'd25, ID_SRAI = 6'd26,
        ID_ADD = 6'd27, ID_SUB = 6'd28, ID_SLL = 6'd29, ID_SLT = 6'd30, ID_SLTU = 6'd31,
        ID_XOR = 6'd32, ID_SRL = 6'd33, ID_SRA = 6'd34, ID_OR = 6'd35, ID_AND = 6'd36;

    localparam logic [6:0]
        OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
        OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LOAD = 7'b0000011,
        OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;

    localparam logic [6:0]  F7_ALT    = 7'b0100000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    typedef struct packed {
        logic       known;
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } dec_t;

    function automatic dec_t decodeId(input logic [5:0] id);
        dec_t d;
        d = '{known: 1'b1, fmt: FMT_I, opcode: OPC_OPIMM, funct3: 3'd0, funct7: 7'd0};
        if (id == ID_LUI)        begin d.fmt = FMT_U;  d.opcode = OPC_LUI;   end
        else if (id == ID_AUIPC) begin d.fmt = FMT_U;  d.opcode = OPC_AUIPC; end
        else if (id == ID_JAL)   begin d.fmt = FMT_J;  d.opcode = OPC_JAL;   end
        else if (id == ID_JALR)  begin d.fmt = FMT_I;  d.opcode = OPC_JALR;  end
        else if (id <= ID_BGEU)  begin d.fmt = FMT_B;  d.opcode = OPC_BR;    end
        else if (id <= ID_LHU)   begin d.fmt = FMT_I;  d.opcode = OPC_LOAD;  end
        else if (id <= ID_SW)    begin d.fmt = FMT_S;  d.opcode = OPC_STORE; end
        else if (id <= ID_ANDI)  begin d.fmt = FMT_I;  d.opcode = OPC_OPIMM; end
        else if (id <= ID_SRAI)  begin d.fmt = FMT_SH; d.opcode = OPC_OPIMM; end
        else if (id <= ID_AND)   begin d.fmt = FMT_R;  d.opcode = OPC_OP;    end
        else                     d.known = 1'b0;

        case (id)
            ID_BNE, ID_LH, ID_SH, ID_SLLI, ID_SLL:                d.funct3 = 3'd1;
            ID_LW, ID_SW, ID_SLTI, ID_SLT:                        d.funct3 = 3'd2;
            ID_SLTIU, ID_SLTU:                                    d.funct3 = 3'd3;
            ID_BLT, ID_LBU, ID_XORI, ID_XOR:                      d.funct3 = 3'd4;
            ID_BGE, ID_LHU, ID_SRLI, ID_SRAI, ID_SRL, ID_SRA:     d.funct3 = 3'd5;
            ID_BLTU, ID_ORI, ID_OR:                               d.funct3 = 3'd6;
            ID_BGEU, ID_ANDI, ID_AND:                             d.funct3 = 3'd7;
            default:                                              d.funct3 = 3'd0;
        endcase

        if (id == ID_SUB || id == ID_SRA || id == ID_SRAI) d.funct7 = F7_ALT;
        return d;
    endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Places a byte-offset immediate into the instruction bit positions of its format and
// reports whether the value fits that format without truncation.
module rv32i_imm_pack
    import rv32i_enc_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [31:0] imm_i,
    output logic [31:0] field_o,
    output logic        rangeOk_o
);

    logic fitsI, fitsB, fitsJ;

    // A value fits a signed field when every bit above the field's sign bit copies it.
    assign fitsI = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign fitsB = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
    assign fitsJ = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

    always_comb begin
        field_o   = '0;
        rangeOk_o = 1'b1;
        case (fmt_i)
            FMT_I: begin
                field_o   = {imm_i[11:0], 20'd0};
                rangeOk_o = fitsI;
            end
            FMT_SH: begin
                field_o   = {7'd0, imm_i[4:0], 20'd0};
                rangeOk_o = (imm_i[31:5] == '0);
            end
            FMT_S: begin
                field_o   = {imm_i[11:5], 13'd0, imm_i[4:0], 7'd0};
                rangeOk_o = fitsI;
            end
            FMT_B: begin
                field_o   = {imm_i[12], imm_i[10:5], 13'd0, imm_i[4:1], imm_i[11], 7'd0};
                rangeOk_o = fitsB && !imm_i[0];
            end
            FMT_U: begin
                field_o   = {imm_i[31:12], 12'd0};
                rangeOk_o = (imm_i[11:0] == '0);
            end
            FMT_J: begin
                field_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'd0};
                rangeOk_o = fitsJ && !imm_i[0];
            end
            default: begin
                field_o   = '0;
                rangeOk_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder and program streamer feeding instruction memory word by word.
// Define RV_ENC_RANGE_CHECK_EN to flag out-of-range immediates as illegal instead of truncating them.
module rv32i_instr_encoder
    import rv32i_enc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [5:0]        in_id_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  logic [31:0]       in_imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_illegal_o,
    output logic              busy_o,
    output logic              done_o
);

`ifdef RV_ENC_RANGE_CHECK_EN
    localparam bit RangeCheck = 1'b1;
`else
    localparam bit RangeCheck = 1'b0;
`endif

    dec_t              dec;
    logic [31:0]       immField;
    logic              rangeOk;
    logic [31:0]       instr_d;
    logic              illegal_d;
    logic              accept, outFire;
    logic              useRs2, useRs1, useF3, useRd, useF7;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q, outAddr_q;
    logic [CNT_W-1:0]  remIn_q, remOut_q;
    logic              outValid_q, outIllegal_q, busy_q, done_q;
    logic [31:0]       outInstr_q;

    assign dec = decodeId(in_id_i);

    rv32i_imm_pack u_immPack (
        .fmt_i     (dec.fmt),
        .imm_i     (in_imm_i),
        .field_o   (immField),
        .rangeOk_o (rangeOk)
    );

    // Register fields are only merged into the word for the formats that carry them.
    always_comb begin
        useF7     = (dec.fmt == FMT_R) || (dec.fmt == FMT_SH);
        useRs2    = (dec.fmt == FMT_R) || (dec.fmt == FMT_S) || (dec.fmt == FMT_B);
        useRs1    = useRs2 || (dec.fmt == FMT_I) || (dec.fmt == FMT_SH);
        useF3     = useRs1;
        useRd     = (dec.fmt == FMT_R) || (dec.fmt == FMT_I) || (dec.fmt == FMT_SH)
                 || (dec.fmt == FMT_U) || (dec.fmt == FMT_J);
        illegal_d = !dec.known || (RangeCheck && !rangeOk);
        instr_d   = immField | {useF7  ? dec.funct7 : 7'd0,
                                useRs2 ? in_rs2_i   : 5'd0,
                                useRs1 ? in_rs1_i   : 5'd0,
                                useF3  ? dec.funct3 : 3'd0,
                                useRd  ? in_rd_i    : 5'd0,
                                dec.opcode};
        if (illegal_d) instr_d = NOP_INSTR;
    end

    assign in_ready_o = (state_q == S_RUN) && (remIn_q != '0) && (!outValid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign outFire    = outValid_q && out_ready_i;

    // remOut counts words still owed to the sink; the session ends when its last word drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remIn_q      <= '0;
            remOut_q     <= '0;
            outValid_q   <= 1'b0;
            outInstr_q   <= '0;
            outAddr_q    <= '0;
            outIllegal_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_q   <= base_addr_i & ~ADDR_W'(3);
                        remIn_q  <= count_i;
                        remOut_q <= count_i;
                        busy_q   <= 1'b1;
                        if (count_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        outValid_q   <= 1'b1;
                        outInstr_q   <= instr_d;
                        outIllegal_q <= illegal_d;
                        outAddr_q    <= addr_q;
                        addr_q       <= addr_q + ADDR_W'(4);
                        remIn_q      <= remIn_q - CNT_W'(1);
                    end else if (outFire) begin
                        outValid_q <= 1'b0;
                    end
                    if (outFire) begin
                        remOut_q <= remOut_q - CNT_W'(1);
                        if (remOut_q == CNT_W'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o   = outValid_q;
    assign out_instr_o   = outInstr_q;
    assign out_addr_o    = outAddr_q;
    assign out_illegal_o = outIllegal_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
